// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller:
// FSM encodings, default sizing and small register-address helpers.
package riscv_hazard_ctrl_pkg;

  // Decode-side fence handling: RUN normally, DRAIN while a fence waits
  // for every outstanding load to retire.
  typedef enum logic [0:0] {
    HC_RUN   = 1'b0,
    HC_DRAIN = 1'b1
  } hc_state_e;

  localparam int HC_MAX_OUT_DEF = 2;
  localparam int HC_CNT_W_DEF   = 32;

  // One-hot mask selecting a single architectural register in the bitmap.
  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    reg_onehot = 32'h0000_0001 << addr;
  endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// Load scoreboard: bitmap of registers awaiting a load writeback, count of
// outstanding loads and a sticky flag for completions with nothing in flight.
module riscv_scoreboard
  import riscv_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_long,   // a load leaves decode this cycle
  input  logic        set_en,       // that load writes a nonzero rd
  input  logic [4:0]  set_addr,
  input  logic        clr_en,       // a load writeback completes
  input  logic [4:0]  clr_addr,
  output logic [31:0] pending,
  output logic [2:0]  out_cnt,
  output logic        underflow
);

  logic [31:0] pending_r;
  logic [31:0] pending_next_s;
  logic [2:0]  out_cnt_r;
  logic [2:0]  out_cnt_next_s;
  logic        underflow_r;
  logic        dec_s;
  logic        bad_done_s;

  // A completion only retires a load when one is actually outstanding.
  assign dec_s      = clr_en & (out_cnt_r != 3'd0);
  assign bad_done_s = clr_en & (out_cnt_r == 3'd0);

  // Next bitmap and count; x0 never tracked, set and clear never collide
  // because a WAW hazard blocks issuing to a still-pending rd.
  always_comb begin
    pending_next_s = pending_r;
    out_cnt_next_s = out_cnt_r;
    if (dec_s) begin
      pending_next_s = pending_next_s & ~reg_onehot(clr_addr);
    end else begin
      pending_next_s = pending_next_s;
    end
    if (issue_long && set_en) begin
      pending_next_s = pending_next_s | reg_onehot(set_addr);
    end else begin
      pending_next_s = pending_next_s;
    end
    pending_next_s[0] = 1'b0;
    if (issue_long && !dec_s) begin
      out_cnt_next_s = out_cnt_r + 3'd1;
    end else if (!issue_long && dec_s) begin
      out_cnt_next_s = out_cnt_r - 3'd1;
    end else begin
      out_cnt_next_s = out_cnt_r;
    end
  end

  // Scoreboard state registers with sticky underflow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= 32'h0000_0000;
      out_cnt_r   <= 3'd0;
      underflow_r <= 1'b0;
    end else begin
      pending_r   <= pending_next_s;
      out_cnt_r   <= out_cnt_next_s;
      underflow_r <= underflow_r | bad_done_s;
    end
  end

  assign pending   = pending_r;
  assign out_cnt   = out_cnt_r;
  assign underflow = underflow_r;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: combines scoreboard lookups, capacity and
// fence conditions into IF/ID stall and flush enables, handles redirects,
// and counts stall cycles.
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int MAX_OUT = HC_MAX_OUT_DEF,
  parameter int CNT_W   = HC_CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_reg_write,
  input  logic             i_id_long,
  input  logic             i_id_fence,
  input  logic             i_ex_redirect,
  input  logic             i_lsu_done,
  input  logic [4:0]       i_lsu_rd_addr,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_issue,
  output logic [31:0]      o_pending,
  output logic             o_busy,
  output logic             o_underflow,
  output logic [CNT_W-1:0] o_stall_cnt
);

  hc_state_e        state_r;
  hc_state_e        state_next_s;
  logic [31:0]      pending_s;
  logic [2:0]       out_cnt_s;
  logic             raw_s;
  logic             waw_s;
  logic             cap_s;
  logic             fwait_s;
  logic             stall_s;
  logic             issue_s;
  logic             rd_nz_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign rd_nz_s = (i_id_rd_addr != 5'd0);

  // Hazards use registered pending only, so a same-cycle writeback still stalls.
  assign raw_s   = (i_id_uses_rs1 & (i_id_rs1_addr != 5'd0) & pending_s[i_id_rs1_addr]) |
                   (i_id_uses_rs2 & (i_id_rs2_addr != 5'd0) & pending_s[i_id_rs2_addr]);
  assign waw_s   = i_id_reg_write & rd_nz_s & pending_s[i_id_rd_addr];
  assign cap_s   = i_id_long & (out_cnt_s == 3'(MAX_OUT));
  assign fwait_s = i_id_fence & (out_cnt_s != 3'd0);

  // A redirect squashes decode, so it overrides any stall.
  assign stall_s = i_id_valid & ~i_ex_redirect &
                   (raw_s | waw_s | cap_s | fwait_s | (state_r == HC_DRAIN));
  assign issue_s = i_id_valid & ~stall_s & ~i_ex_redirect;

  riscv_scoreboard u_scoreboard (
    .clk        (i_clk),
    .rst_n      (i_rstn),
    .issue_long (issue_s & i_id_long),
    .set_en     (i_id_reg_write & rd_nz_s),
    .set_addr   (i_id_rd_addr),
    .clr_en     (i_lsu_done),
    .clr_addr   (i_lsu_rd_addr),
    .pending    (pending_s),
    .out_cnt    (out_cnt_s),
    .underflow  (o_underflow)
  );

  // Fence FSM next state: enter DRAIN on a blocked fence, leave once empty
  // or when the fence is squashed by a redirect.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HC_RUN: begin
        if (i_id_valid && i_id_fence && (out_cnt_s != 3'd0) && !i_ex_redirect) begin
          state_next_s = HC_DRAIN;
        end else begin
          state_next_s = HC_RUN;
        end
      end
      HC_DRAIN: begin
        if ((out_cnt_s == 3'd0) || i_ex_redirect) begin
          state_next_s = HC_RUN;
        end else begin
          state_next_s = HC_DRAIN;
        end
      end
      default: state_next_s = HC_RUN;
    endcase
  end

  // Fence FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= HC_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Saturating count of decode stall cycles.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_if  = stall_s;
  assign o_stall_id  = stall_s;
  assign o_flush_id  = i_ex_redirect;
  assign o_flush_ex  = i_ex_redirect | stall_s;
  assign o_issue     = issue_s;
  assign o_pending   = pending_s;
  assign o_busy      = (out_cnt_s != 3'd0);
  assign o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl: a trace table of per-cycle inputs and
// hand-computed outputs, followed by underflow and mid-stall reset sequences.
module tb_riscv_hazard_ctrl;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        uses1, uses2, regw, lng, fence, redirect, done;
  logic [4:0]  lsu_rd;
  logic        stall_if, stall_id, flush_id, flush_ex, issue, busy, underflow;
  logic [31:0] pending;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  riscv_hazard_ctrl #(.MAX_OUT(2), .CNT_W(32)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_id_valid     (id_valid),
    .i_id_rs1_addr  (rs1),
    .i_id_rs2_addr  (rs2),
    .i_id_rd_addr   (rd),
    .i_id_uses_rs1  (uses1),
    .i_id_uses_rs2  (uses2),
    .i_id_reg_write (regw),
    .i_id_long      (lng),
    .i_id_fence     (fence),
    .i_ex_redirect  (redirect),
    .i_lsu_done     (done),
    .i_lsu_rd_addr  (lsu_rd),
    .o_stall_if     (stall_if),
    .o_stall_id     (stall_id),
    .o_flush_id     (flush_id),
    .o_flush_ex     (flush_ex),
    .o_issue        (issue),
    .o_pending      (pending),
    .o_busy         (busy),
    .o_underflow    (underflow),
    .o_stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, lg, fe, red, done;
    logic [4:0]  lrd;
    logic        e_stall, e_fid, e_fex, e_iss;
    logic [31:0] e_pend;
    logic        e_busy, e_uf;
    logic [31:0] e_scnt;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v;   rs1 = r.rs1;  rs2 = r.rs2;  rd = r.rd;
    uses1 = r.u1;     uses2 = r.u2; regw = r.rw;  lng = r.lg;
    fence = r.fe;     redirect = r.red; done = r.done; lsu_rd = r.lrd;
  endtask

  task automatic idle();
    id_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    uses1 = 1'b0; uses2 = 1'b0; regw = 1'b0; lng = 1'b0;
    fence = 1'b0; redirect = 1'b0; done = 1'b0; lsu_rd = 5'd0;
  endtask

  initial begin
    // v rs1 rs2 rd  u1 u2 rw lg fe red done lrd | stall fid fex iss pend busy uf scnt
    // load-use: load x5, consumer stalls 3 cycles, writeback in the third
    tbl[0]  = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,32'd0};
    tbl[1]  = '{1'b1,5'd0,5'd0,5'd5,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd0};
    tbl[2]  = '{1'b1,5'd5,5'd0,5'd6,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h20, 1'b1,1'b0,32'd0};
    tbl[3]  = '{1'b1,5'd5,5'd0,5'd6,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h20, 1'b1,1'b0,32'd1};
    tbl[4]  = '{1'b1,5'd5,5'd0,5'd6,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd5, 1'b1,1'b0,1'b1,1'b0,32'h20, 1'b1,1'b0,32'd2};
    tbl[5]  = '{1'b1,5'd5,5'd0,5'd6,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd3};
    // x0: load to x0 counts but sets no bit, reader of x0 never stalls
    tbl[6]  = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd3};
    tbl[7]  = '{1'b1,5'd0,5'd0,5'd7,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b1,1'b0,32'd3};
    tbl[8]  = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,32'd3};
    tbl[9]  = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,32'd3};
    // capacity: two loads fill MAX_OUT, third stalls until a completion
    tbl[10] = '{1'b1,5'd0,5'd0,5'd1,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd3};
    tbl[11] = '{1'b1,5'd0,5'd0,5'd2,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h2,  1'b1,1'b0,32'd3};
    tbl[12] = '{1'b1,5'd0,5'd0,5'd3,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h6,  1'b1,1'b0,32'd3};
    tbl[13] = '{1'b1,5'd0,5'd0,5'd3,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,5'd1, 1'b1,1'b0,1'b1,1'b0,32'h6,  1'b1,1'b0,32'd4};
    tbl[14] = '{1'b1,5'd0,5'd0,5'd3,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,5'd2, 1'b0,1'b0,1'b0,1'b1,32'h4,  1'b1,1'b0,32'd5};
    tbl[15] = '{1'b1,5'd0,5'd0,5'd4,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h8,  1'b1,1'b0,32'd5};
    tbl[16] = '{1'b1,5'd0,5'd0,5'd9,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h18, 1'b1,1'b0,32'd5};
    // fence drain: two loads outstanding
    tbl[17] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h18, 1'b1,1'b0,32'd6};
    tbl[18] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd3, 1'b1,1'b0,1'b1,1'b0,32'h18, 1'b1,1'b0,32'd7};
    tbl[19] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd4, 1'b1,1'b0,1'b1,1'b0,32'h10, 1'b1,1'b0,32'd8};
    tbl[20] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h0,  1'b0,1'b0,32'd9};
    tbl[21] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd10};
    // redirect during a RAW stall on rs2, pending survives
    tbl[22] = '{1'b1,5'd0,5'd0,5'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h0,  1'b0,1'b0,32'd10};
    tbl[23] = '{1'b1,5'd0,5'd8,5'd10, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h100,1'b1,1'b0,32'd10};
    tbl[24] = '{1'b1,5'd0,5'd8,5'd10, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,1'b1,1'b1,1'b0,32'h100,1'b1,1'b0,32'd11};
    tbl[25] = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,32'h100,1'b1,1'b0,32'd11};
    // WAW on x8, then fence entering DRAIN and leaving on redirect
    tbl[26] = '{1'b1,5'd0,5'd0,5'd8,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h100,1'b1,1'b0,32'd11};
    tbl[27] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1,1'b0,32'h100,1'b1,1'b0,32'd12};
    tbl[28] = '{1'b1,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd0, 1'b0,1'b1,1'b1,1'b0,32'h100,1'b1,1'b0,32'd13};
    tbl[29] = '{1'b1,5'd0,5'd0,5'd11, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,32'h100,1'b1,1'b0,32'd13};
    tbl[30] = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd8, 1'b0,1'b0,1'b0,1'b0,32'h100,1'b1,1'b0,32'd13};
    tbl[31] = '{1'b0,5'd0,5'd0,5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,32'd13};

    // reset state
    idle();
    rstn = 1'b0;
    #12;
    chk("rst stall",  {31'd0, stall_id}, 32'd0);
    chk("rst flush",  {30'd0, flush_id, flush_ex}, 32'd0);
    chk("rst issue",  {31'd0, issue}, 32'd0);
    chk("rst pend",   pending, 32'd0);
    chk("rst busy",   {31'd0, busy}, 32'd0);
    chk("rst uf",     {31'd0, underflow}, 32'd0);
    chk("rst scnt",   stall_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // trace table
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d stall_if", i), {31'd0, stall_if}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d stall_id", i), {31'd0, stall_id}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d flush_id", i), {31'd0, flush_id}, {31'd0, tbl[i].e_fid});
      chk($sformatf("v%0d flush_ex", i), {31'd0, flush_ex}, {31'd0, tbl[i].e_fex});
      chk($sformatf("v%0d issue", i),    {31'd0, issue},    {31'd0, tbl[i].e_iss});
      chk($sformatf("v%0d pending", i),  pending,           tbl[i].e_pend);
      chk($sformatf("v%0d busy", i),     {31'd0, busy},     {31'd0, tbl[i].e_busy});
      chk($sformatf("v%0d underflow", i),{31'd0, underflow},{31'd0, tbl[i].e_uf});
      chk($sformatf("v%0d stall_cnt", i),stall_cnt,         tbl[i].e_scnt);
    end

    // completion with nothing outstanding sets a sticky underflow
    @(negedge clk);
    idle();
    done = 1'b1;
    lsu_rd = 5'd3;
    @(negedge clk);
    idle();
    #1;
    chk("uf set",    {31'd0, underflow}, 32'd1);
    chk("uf busy",   {31'd0, busy}, 32'd0);
    chk("uf pend",   pending, 32'd0);
    @(negedge clk);
    #1;
    chk("uf sticky", {31'd0, underflow}, 32'd1);

    // reset asserted in the middle of a RAW stall
    @(negedge clk);
    id_valid = 1'b1; rd = 5'd5; regw = 1'b1; lng = 1'b1;
    #1;
    chk("rs issue load", {31'd0, issue}, 32'd1);
    @(negedge clk);
    idle();
    id_valid = 1'b1; rs1 = 5'd5; uses1 = 1'b1; rd = 5'd6; regw = 1'b1;
    #1;
    chk("rs stall before", {31'd0, stall_id}, 32'd1);
    chk("rs scnt before",  stall_cnt, 32'd13);
    #1;
    rstn = 1'b0;
    #1;
    chk("rs stall", {31'd0, stall_id}, 32'd0);
    chk("rs pend",  pending, 32'd0);
    chk("rs busy",  {31'd0, busy}, 32'd0);
    chk("rs uf",    {31'd0, underflow}, 32'd0);
    chk("rs scnt",  stall_cnt, 32'd0);
    @(negedge clk);
    idle();
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst pend", pending, 32'd0);
    chk("post rst scnt", stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
